// File: rtl/dsp_buf_readout.sv
// dsp_buf_readout: command-driven burst readout engine. Drains one of NBUF
// read-latency buffers onto a valid/ready stream through a small output FIFO,
// keeping full throughput under backpressure and supporting abort.
module dsp_buf_readout #(
    parameter int NBUF         = 8,
    parameter int DATAWIDTH    = 32,
    parameter int ADDRWIDTH    = 13,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4,
    localparam int SELW        = (NBUF > 1) ? $clog2(NBUF) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [SELW-1:0]           cmd_sel,
    input  logic [ADDRWIDTH-1:0]      cmd_addr,
    input  logic [ADDRWIDTH:0]        cmd_len,
    input  logic                      abort,
    output logic [ADDRWIDTH-1:0]      buf_read_addr,
    input  logic [NBUF*DATAWIDTH-1:0] buf_read_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATAWIDTH-1:0]      out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int FCW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDRWIDTH:0] LEN_ONE = {{ADDRWIDTH{1'b0}}, 1'b1};

    // Elaboration-time parameter sanity checks
    if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_chk_depth
        $error("dsp_buf_readout: FIFO_DEPTH must be >= READ_LATENCY+2");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_chk_lat
        $error("dsp_buf_readout: READ_LATENCY must be in 1..4");
    end
    if (NBUF < 1) begin : g_chk_nbuf
        $error("dsp_buf_readout: NBUF must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FLUSH
    } state_t;

    state_t                 state_q, state_d;
    logic                   done_q, done_d;
    logic [SELW-1:0]        sel_q;
    logic [ADDRWIDTH-1:0]   addr_q;
    logic [ADDRWIDTH:0]     rem_q;
    logic [READ_LATENCY-1:0] vld_sr, last_sr;
    logic [FCW-1:0]         flush_cnt;

    logic [DATAWIDTH-1:0]   fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_last;
    logic [PTRW-1:0]        wr_ptr, rd_ptr;
    logic [CNTW-1:0]        count;

    logic                   accept, abort_act, issue, push, pop;
    logic [31:0]            inflight, used;
    logic [DATAWIDTH-1:0]   rd_word;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_word       = buf_read_data[int'(sel_q) * DATAWIDTH +: DATAWIDTH];
    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign buf_read_addr = addr_q;
    assign out_valid     = (count != '0);
    assign out_data      = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last      = out_valid & fifo_last[rd_ptr];

    // Handshakes, issue throttling and next-state / done decode
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        inflight  = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            if (vld_sr[i]) inflight = inflight + 32'd1;
        end
        pop       = out_valid && out_ready;
        accept    = cmd_valid && cmd_ready;
        abort_act = abort && (state_q == ISSUE || state_q == DRAIN);
        // Reads still in flight will land in the FIFO, so they reserve space now
        used      = inflight + 32'(count) - 32'(pop);
        issue     = (state_q == ISSUE) && !abort_act && (used < 32'(FIFO_DEPTH));
        push      = vld_sr[READ_LATENCY-1] && !abort_act &&
                    (state_q == ISSUE || state_q == DRAIN);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_len == '0) done_d  = 1'b1;
                    else               state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (abort_act)                     state_d = FLUSH;
                else if (issue && rem_q == LEN_ONE) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort_act) begin
                    state_d = FLUSH;
                end else if (vld_sr == '0 &&
                             (count == '0 || (count == CNTW'(1) && pop))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt == FCW'(READ_LATENCY - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and registered done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Command latch plus address / remaining-count advance on each issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q  <= '0;
            addr_q <= '0;
            rem_q  <= '0;
        end else if (accept) begin
            sel_q  <= cmd_sel;
            addr_q <= cmd_addr;
            rem_q  <= cmd_len;
        end else if (issue) begin
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
        end
    end

    // Return-path tracker: one valid/last bit per outstanding read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= issue;
            last_sr[0] <= issue && (rem_q == LEN_ONE);
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    // FLUSH dwell counter: discard returning data for READ_LATENCY cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              flush_cnt <= '0;
        else if (state_q != FLUSH) flush_cnt <= '0;
        else                       flush_cnt <= flush_cnt + 1'b1;
    end

    // FIFO pointers and occupancy; abort empties the FIFO at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort_act) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNTW'(push) - CNTW'(pop);
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= rd_word;
            fifo_last[wr_ptr] <= last_sr[READ_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_dsp_buf_readout.sv
// tb_dsp_buf_readout: randomized and directed bursts against a queue-based
// reference of the expected beat stream, plus latency checks.
module tb_dsp_buf_readout;

    localparam int NBUF  = 4;
    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int LW    = AW + 1;
    localparam int RL    = 3;
    localparam int FD    = 5;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_sel = '0;
    logic [AW-1:0]     cmd_addr = '0;
    logic [AW:0]       cmd_len = '0;
    logic              abort = 1'b0;
    logic [AW-1:0]     buf_read_addr;
    logic [NBUF*DW-1:0] buf_read_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;
    int rdy_pct  = 100;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         e_cur;
    logic [DW-1:0] seen [64];
    int            seen_n = 0;
    logic          prev_stall = 1'b0;
    logic          prev_done  = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    logic [AW-1:0] apipe [RL];

    dsp_buf_readout #(
        .NBUF(NBUF),
        .DATAWIDTH(DW),
        .ADDRWIDTH(AW),
        .READ_LATENCY(RL),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .abort(abort),
        .buf_read_addr(buf_read_addr),
        .buf_read_data(buf_read_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Buffer contents: a fixed, per-buffer distinct pattern of the address
    function automatic logic [DW-1:0] mem_val(input int k, input int a);
        return DW'((k * 32'h1111) ^ (a * 32'h0305) ^ 32'h5A5A);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Buffer bank with READ_LATENCY registered read stages
    always @(posedge clk) begin
        apipe[0] <= buf_read_addr;
        for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
    end

    always_comb begin
        buf_read_data = '0;
        for (int k = 0; k < NBUF; k++)
            buf_read_data[k*DW +: DW] = mem_val(k, int'(apipe[RL-1]));
    end

    // Sink readiness: random duty set by rdy_pct
    always @(posedge clk) begin
        #1;
        out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
    end

    // Compare process: every accepted beat against the expected stream
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(prev_data));
                chk("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected_pending", exp_q.size(), 1);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("beat_data", 32'(out_data), 32'(e_cur.data));
                    chk("beat_last", 32'(out_last), 32'(e_cur.last));
                    if (seen_n < 64) seen[seen_n] = out_data;
                    seen_n++;
                end
            end
            if (done) chk("busy_at_done", 32'(busy), 0);
            if (prev_done) chk("done_single_cycle", 32'(done), 0);
            prev_done  = done;
            prev_stall = out_valid && !out_ready && !abort;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic issue_cmd(input int sel, input int addr, input int len);
        int    n;
        beat_t b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_sel   = 2'(sel);
        cmd_addr  = AW'(addr);
        cmd_len   = LW'(len);
        seen_n    = 0;
        n         = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_for_accept", 32'(cmd_ready), 1);
        for (int i = 0; i < len; i++) begin
            b.data = mem_val(sel, (addr + i) % DEPTH);
            b.last = (i == len - 1);
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Counts cycles from the cycle after acceptance (cycle 1) to done
    task automatic wait_done(output int fl, output int ll, output int dl, output int vc);
        int n;
        fl = -1; ll = -1; dl = -1; vc = 0; n = 0;
        while (dl < 0 && n < 2000) begin
            @(negedge clk);
            n++;
            if (out_valid && fl < 0) fl = n;
            if (out_valid && out_ready) begin
                vc++;
                if (out_last) ll = n;
            end
            if (done) dl = n;
        end
        if (dl < 0) chk("done_seen", 32'(done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int fl, ll, dl, vc, cnt, sel, addr, len;

        // Reset values
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(buf_read_addr), 0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Basic burst: first beat at RL+2=5, last at 12, done at 13
        issue_cmd(2, 'h10, 8);
        wait_done(fl, ll, dl, vc);
        chk("basic_first_lat", fl, 5);
        chk("basic_last_cyc", ll, 12);
        chk("basic_done_lat", dl, 13);
        chk("basic_beats", vc, 8);
        chk("basic_first_data", 32'(seen[0]), 32'(mem_val(2, 'h10)));
        chk("basic_last_data", 32'(seen[7]), 32'(mem_val(2, 'h17)));
        chk("basic_drained", exp_q.size(), 0);

        // Wrap-around: 30, 31, 0, 1, 2
        issue_cmd(1, 30, 5);
        wait_done(fl, ll, dl, vc);
        chk("wrap_beats", vc, 5);
        chk("wrap_beat3", 32'(seen[2]), 32'(mem_val(1, 0)));
        chk("wrap_beat5", 32'(seen[4]), 32'(mem_val(1, 2)));
        chk("wrap_no_gaps", ll - fl, 4);

        // Backpressure at 30% ready duty
        rdy_pct = 30;
        issue_cmd(2, 9, 32);
        wait_done(fl, ll, dl, vc);
        chk("bp_beats", vc, 32);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_last_data", 32'(seen[31]), 32'(mem_val(2, 8)));
        rdy_pct = 100;

        // Abort raised in cycle 7: beats in cycles 5..7 only, done 4 cycles later
        issue_cmd(3, 0, 32);
        repeat (6) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_beats_before", seen_n, 3);
        exp_q.delete();
        wait_done(fl, ll, dl, vc);
        chk("abort_done_lat", dl, 4);
        chk("abort_no_valid", fl, -1);
        chk("abort_no_beats", vc, 0);
        chk("abort_cmd_ready", 32'(cmd_ready), 1);

        // Follow-up after abort
        issue_cmd(3, 20, 2);
        wait_done(fl, ll, dl, vc);
        chk("follow_done_lat", dl, 7);
        chk("follow_beats", vc, 2);
        chk("follow_data0", 32'(seen[0]), 32'(mem_val(3, 20)));
        chk("follow_data1", 32'(seen[1]), 32'(mem_val(3, 21)));

        // len=0: done on the next cycle, no beats
        issue_cmd(1, 3, 0);
        wait_done(fl, ll, dl, vc);
        chk("len0_done_lat", dl, 1);
        chk("len0_beats", vc, 0);

        // Full-buffer burst from address 5 ending at address 4
        issue_cmd(0, 5, DEPTH);
        wait_done(fl, ll, dl, vc);
        chk("full_beats", vc, 32);
        chk("full_done_lat", dl, 37);
        chk("full_first", 32'(seen[0]), 32'(mem_val(0, 5)));
        chk("full_end", 32'(seen[31]), 32'(mem_val(0, 4)));

        // Reset asserted in DRAIN (cycle 10 of a len=8 burst)
        issue_cmd(2, 0, 8);
        repeat (9) @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(busy), 1);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_last", 32'(out_last), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_addr", 32'(buf_read_addr), 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy || out_valid) cnt++;
        end
        chk("post_reset_quiet", cnt, 0);
        issue_cmd(1, 17, 6);
        wait_done(fl, ll, dl, vc);
        chk("post_reset_done_lat", dl, 11);
        chk("post_reset_beats", vc, 6);
        chk("post_reset_drained", exp_q.size(), 0);

        // Randomized bursts
        for (int it = 0; it < 8; it++) begin
            sel  = int'($urandom_range(0, NBUF - 1));
            addr = int'($urandom_range(0, DEPTH - 1));
            len  = int'($urandom_range(1, DEPTH));
            rdy_pct = (it % 2 == 0) ? 100 : 20 + int'($urandom_range(0, 60));
            issue_cmd(sel, addr, len);
            wait_done(fl, ll, dl, vc);
            chk("rand_beats", vc, len);
            chk("rand_drained", exp_q.size(), 0);
            if (rdy_pct == 100) chk("rand_done_lat", dl, len + RL + 2);
        end
        rdy_pct = 100;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
